// File: rtl/nv_cacc_abuf_pkg.sv
// Shared constants and enums for the accumulation-buffer port controller.
package nv_cacc_abuf_pkg;
    localparam int DEPTH        = 32;
    localparam int AW           = 5;
    localparam int CW           = 6;
    localparam int STARVE_LIMIT = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {NONE, ACC, DLV}   owner_t;
endpackage

// File: rtl/nv_cacc_abuf_arb.sv
// Read-port arbiter: accumulator priority with a starvation escape for delivery.
module nv_cacc_abuf_arb
    import nv_cacc_abuf_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   acc_req,
    input  logic   dlv_req,
    input  logic   stall,
    output owner_t grant
);
    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    always_comb begin
        grant = NONE;
        if (!stall) begin
            if (dlv_req && (!acc_req || starve_cnt == LIMIT))
                grant = DLV;
            else if (acc_req)
                grant = ACC;
        end
    end

    // Counter saturates at the limit so a stall cannot wrap it back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant == DLV || !dlv_req)
            starve_cnt <= '0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: rtl/nv_cacc_abuf_ctrl.sv
// Accumulation-buffer RAM port controller: read arbitration, done tracking, in-order retire.
// Optional NV_CACC_ABUF_PERF_EN adds saturating stall counters per requester.
module nv_cacc_abuf_ctrl
    import nv_cacc_abuf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          op_start,
    input  logic          op_last,
    input  logic          acc_rd_valid,
    input  logic [AW-1:0] acc_rd_addr,
    output logic          acc_rd_ready,
    input  logic          acc_wr_valid,
    input  logic [AW-1:0] acc_wr_addr,
    input  logic          acc_wr_last,
    output logic          acc_data_vld,
    output logic          dlv_valid,
    input  logic          dlv_ready,
    output logic [AW-1:0] dlv_addr,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [CW-1:0] occupancy,
    output logic          op_done,
    output logic          err_ovr
`ifdef NV_CACC_ABUF_PERF_EN
    ,
    output logic [31:0]   perf_acc_stall,
    output logic [31:0]   perf_dlv_stall
`endif
);
    state_t           state;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] done_nxt;
    logic [AW-1:0]    dlv_ptr;
    logic             active;
    logic             stall;
    logic             acc_req;
    logic             dlv_req;
    logic             issue;
    logic             done_set;
    logic             occ_inc;
    logic             err_hit;
    owner_t           grant;

    assign active   = (state != IDLE);
    assign stall    = dlv_valid & ~dlv_ready;
    assign acc_req  = active & acc_rd_valid;
    assign dlv_req  = active & done[dlv_ptr];

    nv_cacc_abuf_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .acc_req (acc_req),
        .dlv_req (dlv_req),
        .stall   (stall),
        .grant   (grant)
    );

    assign issue        = (grant == DLV);
    assign acc_rd_ready = (grant == ACC);
    assign ram_re       = issue | acc_rd_ready;
    assign ram_ra       = issue ? dlv_ptr : (acc_rd_ready ? acc_rd_addr : '0);
    assign ram_we       = active & acc_wr_valid;
    assign ram_wa       = ram_we ? acc_wr_addr : '0;
    assign done_set     = ram_we & acc_wr_last;

    // Occupancy follows the bitmap: only a real 0->1 transition counts as a new entry.
    assign occ_inc = done_set & (~done[acc_wr_addr] | (issue & (dlv_ptr == acc_wr_addr)));
    assign err_hit = active & ((acc_rd_valid & done[acc_rd_addr]) |
                               (acc_wr_valid & done[acc_wr_addr]));

    always_comb begin
        done_nxt = done;
        if (issue)
            done_nxt[dlv_ptr] = 1'b0;
        if (done_set)
            done_nxt[acc_wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= '0;
            dlv_ptr      <= '0;
            occupancy    <= '0;
            err_ovr      <= 1'b0;
            acc_data_vld <= 1'b0;
            dlv_valid    <= 1'b0;
            dlv_addr     <= '0;
        end else begin
            done         <= done_nxt;
            occupancy    <= occupancy + CW'(occ_inc) - CW'(issue);
            err_ovr      <= err_ovr | err_hit;
            acc_data_vld <= acc_rd_ready;
            dlv_valid    <= issue | stall;
            if (issue) begin
                dlv_ptr  <= dlv_ptr + 1'b1;
                dlv_addr <= dlv_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_done <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE:    if (op_start) state <= RUN;
                RUN:     if (op_last)  state <= DRAIN;
                DRAIN: begin
                    if (occupancy == '0 && !dlv_valid && !done_set) begin
                        state   <= IDLE;
                        op_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NV_CACC_ABUF_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_acc_stall <= '0;
            perf_dlv_stall <= '0;
        end else if (state == IDLE && op_start) begin
            perf_acc_stall <= '0;
            perf_dlv_stall <= '0;
        end else begin
            if (acc_req && !acc_rd_ready && !(&perf_acc_stall))
                perf_acc_stall <= perf_acc_stall + 1'b1;
            if (dlv_req && !issue && !(&perf_dlv_stall))
                perf_dlv_stall <= perf_dlv_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_nv_cacc_abuf_ctrl.sv
// Directed + randomized bench for nv_cacc_abuf_ctrl against a per-cycle reference model.
module tb_nv_cacc_abuf_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       op_start, op_last;
    logic       acc_rd_valid, acc_rd_ready;
    logic [4:0] acc_rd_addr;
    logic       acc_wr_valid, acc_wr_last;
    logic [4:0] acc_wr_addr;
    logic       acc_data_vld, dlv_valid, dlv_ready;
    logic [4:0] dlv_addr;
    logic       ram_re, ram_we;
    logic [4:0] ram_ra, ram_wa;
    logic [5:0] occupancy;
    logic       op_done, err_ovr;

    nv_cacc_abuf_ctrl dut (
        .clk(clk), .rst(rst), .op_start(op_start), .op_last(op_last),
        .acc_rd_valid(acc_rd_valid), .acc_rd_addr(acc_rd_addr), .acc_rd_ready(acc_rd_ready),
        .acc_wr_valid(acc_wr_valid), .acc_wr_addr(acc_wr_addr), .acc_wr_last(acc_wr_last),
        .acc_data_vld(acc_data_vld), .dlv_valid(dlv_valid), .dlv_ready(dlv_ready),
        .dlv_addr(dlv_addr), .ram_re(ram_re), .ram_ra(ram_ra), .ram_we(ram_we),
        .ram_wa(ram_wa), .occupancy(occupancy), .op_done(op_done), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    // Reference model: spec-level state held as plain integers and a bit array.
    int  m_state;            // 0 idle, 1 run, 2 drain
    bit  m_done [32];
    int  m_ptr, m_starve, m_daddr;
    bit  m_dv, m_accv, m_err, m_opdone;
    int  n_vec = 0, n_miss = 0;
    int  max_occ = 0;
    bit  s_re, s_ardy;
    int  s_ra;
    int  q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int popc();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_done[i]);
        return c;
    endfunction

    task automatic m_reset();
        m_state = 0; m_ptr = 0; m_starve = 0; m_daddr = 0;
        m_dv = 0; m_accv = 0; m_err = 0; m_opdone = 0;
        for (int i = 0; i < 32; i++) m_done[i] = 0;
    endtask

    task automatic idle_in();
        op_start = 0; op_last = 0; acc_rd_valid = 0; acc_rd_addr = 0;
        acc_wr_valid = 0; acc_wr_addr = 0; acc_wr_last = 0;
    endtask

    task automatic wr(input int a, input bit last);
        acc_wr_valid = 1; acc_wr_addr = 5'(a); acc_wr_last = last;
    endtask

    task automatic wr_off();
        acc_wr_valid = 0; acc_wr_last = 0;
    endtask

    // One clock: check every output against the model, advance the model, cross the edge.
    task automatic step();
        bit active, stall, dreq, areq, gd, ga, we, set;
        int exp_ra, occ_now;
        #2;
        s_re = ram_re; s_ra = int'(ram_ra); s_ardy = acc_rd_ready;
        if (rst) m_reset();
        active = (m_state != 0);
        stall  = m_dv && !dlv_ready;
        dreq   = active && m_done[m_ptr];
        areq   = active && acc_rd_valid;
        gd     = !stall && dreq && (!areq || m_starve >= 8);
        ga     = !stall && areq && !gd;
        we     = active && acc_wr_valid;
        exp_ra = gd ? m_ptr : (ga ? int'(acc_rd_addr) : 0);
        occ_now = popc();
        chk("ram_re", ram_re, ga | gd);
        chk("acc_rd_ready", acc_rd_ready, ga);
        chk("ram_ra", ram_ra, exp_ra);
        chk("ram_we", ram_we, we);
        chk("ram_wa", ram_wa, we ? int'(acc_wr_addr) : 0);
        chk("acc_data_vld", acc_data_vld, m_accv);
        chk("dlv_valid", dlv_valid, m_dv);
        chk("dlv_addr", dlv_addr, m_daddr);
        chk("occupancy", occupancy, occ_now);
        chk("op_done", op_done, m_opdone);
        chk("err_ovr", err_ovr, m_err);
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (!rst) begin
            set = we && acc_wr_last;
            if (active && ((acc_rd_valid && m_done[acc_rd_addr]) || (acc_wr_valid && m_done[acc_wr_addr])))
                m_err = 1;
            m_starve = (gd || !dreq) ? 0 : ((m_starve < 8) ? m_starve + 1 : 8);
            m_opdone = 0;
            case (m_state)
                0: if (op_start) m_state = 1;
                1: if (op_last) m_state = 2;
                default: if (occ_now == 0 && !m_dv && !set) begin m_state = 0; m_opdone = 1; end
            endcase
            m_dv   = gd || (m_dv && !dlv_ready);
            m_accv = ga;
            if (gd) begin
                m_daddr = m_ptr;
                m_done[m_ptr] = 0;
                m_ptr = (m_ptr + 1) % 32;
            end
            if (set) m_done[acc_wr_addr] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic note_dlv();
        if (s_re && !s_ardy) q.push_back(s_ra);
    endtask

    initial begin
        int gk, npulse, wr_next;
        idle_in(); dlv_ready = 0; rst = 1;
        m_reset();
        step(); step();
        chk("rst_dlv_valid", dlv_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        rst = 0;

        // 1: four entries complete in order, retired back to back
        op_start = 1; step(); op_start = 0;
        dlv_ready = 1; q.delete();
        for (int a = 0; a < 4; a++) begin wr(a, 1); step(); note_dlv(); end
        wr_off();
        for (int i = 0; i < 4; i++) begin step(); note_dlv(); end
        chk("t1_dlv_count", q.size(), 4);
        for (int i = 0; i < q.size() && i < 4; i++) chk("t1_dlv_order", q[i], i);
        chk("t1_occ_end", occupancy, 0);

        // 2: delivery starved by a continuous acc read
        acc_rd_valid = 1; acc_rd_addr = 10; wr(4, 1); step(); wr_off();
        gk = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (gk == 0 && s_re && !s_ardy && s_ra == 4) gk = k;
        end
        chk("t2_starve_grant_cycle", gk, 9);
        acc_rd_valid = 0; step(); step();

        // 3: consumer stall blocks both requesters
        dlv_ready = 0; wr(5, 1); step(); wr_off(); step();
        chk("t3_dlv_valid", dlv_valid, 1);
        acc_rd_valid = 1; acc_rd_addr = 12;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_no_read", s_re, 0);
            chk("t3_stall_addr", dlv_addr, 5);
        end
        dlv_ready = 1; step();
        chk("t3_resume_read", s_re, 1);
        acc_rd_valid = 0; step();

        // 4: fill all entries, drain, then wrap 31 -> 0
        dlv_ready = 0; max_occ = 0;
        for (int a = 0; a < 32; a++) begin wr(a, 1); step(); end
        wr_off();
        chk("t4_occ_full", occupancy, 31);
        dlv_ready = 1;
        for (int i = 0; i < 40; i++) step();
        chk("t4_occ_drained", occupancy, 0);
        q.delete();
        for (int a = 6; a <= 32; a++) begin wr(a % 32, 1); step(); note_dlv(); end
        wr_off();
        for (int i = 0; i < 3; i++) begin step(); note_dlv(); end
        chk("t4_wrap_len", q.size(), 27);
        if (q.size() >= 2) begin
            chk("t4_wrap_31", q[q.size()-2], 31);
            chk("t4_wrap_0", q[q.size()-1], 0);
        end
        chk("t4_occ_le_32", max_occ <= 32, 1);

        // 5: drain with three entries outstanding; op_start in RUN ignored
        dlv_ready = 0;
        op_start = 1; step(); op_start = 0;
        for (int a = 1; a <= 3; a++) begin wr(a, 1); step(); end
        wr_off();
        op_last = 1; step(); op_last = 0;
        npulse = 0;
        for (int i = 0; i < 5; i++) begin step(); if (op_done) npulse++; end
        chk("t5_no_done_while_stalled", npulse, 0);
        dlv_ready = 1; npulse = 0;
        for (int i = 0; i < 20; i++) begin step(); if (op_done) npulse++; end
        chk("t5_op_done_pulses", npulse, 1);

        // 6: overwrite of a complete entry, then async reset mid-drain
        op_start = 1; step(); op_start = 0;
        dlv_ready = 0;
        wr(7, 1); step(); wr(7, 0); step(); wr_off();
        chk("t6_err_next_cycle", err_ovr, 1);
        wr(4, 1); step(); wr_off(); step();
        op_last = 1; step(); op_last = 0;
        step(); step();
        chk("t6_err_sticky", err_ovr, 1);
        chk("t6_dv_before_rst", dlv_valid, 1);
        rst = 1; #1;
        chk("t6_async_dlv_valid", dlv_valid, 0);
        chk("t6_async_err", err_ovr, 0);
        chk("t6_async_occ", occupancy, 0);
        chk("t6_async_re", ram_re, 0);
        m_reset();
        step(); rst = 0; step();

        // 7: randomized traffic with in-order completion, then drain
        op_start = 1; step(); op_start = 0;
        wr_next = m_ptr;
        for (int i = 0; i < 400; i++) begin
            acc_rd_valid = 1'($urandom_range(0, 1));
            acc_rd_addr  = 5'($urandom_range(0, 31));
            acc_wr_valid = ($urandom_range(0, 2) != 0);
            acc_wr_addr  = 5'($urandom_range(0, 31));
            acc_wr_last  = 0;
            if (acc_wr_valid && $urandom_range(0, 1) == 1 && !m_done[wr_next]) begin
                acc_wr_addr = 5'(wr_next); acc_wr_last = 1;
                wr_next = (wr_next + 1) % 32;
            end
            dlv_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_in(); dlv_ready = 1;
        op_last = 1; step(); op_last = 0;
        npulse = 0;
        for (int i = 0; i < 80; i++) begin step(); if (op_done) npulse++; end
        chk("t7_random_drain_done", npulse, 1);
        chk("t7_random_occ_end", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
